mc_ctrl: RTL and testbench

Multicycle control unit for the MIPS-subset CPU datapath. Sequences instruction fetch, decode, execute, memory and write-back phases by driving every datapath write-enable and mux select from a state machine plus the latched opcode/funct. Also sequences CP0 traffic (mfc0/mtc0/eret), peripheral-bridge loads and stores, and interrupt entry between instructions.

---
 rtl/mc_ctrl_if.sv | 44 ++++
 rtl/mc_ctrl.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control/datapath bundle for the multicycle MIPS controller: IR fields and
// ALU/bridge/CP0 flags in, datapath enables and mux selects out.
interface mc_ctrl_if;
  localparam int unsigned OP_W = 6;
  localparam int unsigned RS_W = 5;

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic [RS_W-1:0] rs_out;
  logic            zero;
  logic            flow;
  logic            dev_sel;
  logic            intreq;

  logic            PCWr;
  logic            IRWr;
  logic            GPRWr;
  logic            DMWr;
  logic            Bsel;
  logic            MemByte;
  logic [2:0]      WDsel;
  logic [1:0]      GPRsel;
  logic [1:0]      Extop;
  logic [1:0]      ALUOp;
  logic [1:0]      ALUsel;
  logic [1:0]      NPCOp;
  logic            PrWe;
  logic            CP0We;
  logic            EXLSet;
  logic            EXLClr;
  logic            eret;

  modport master (
    input  opcode, funct, rs_out, zero, flow, dev_sel, intreq,
    output PCWr, IRWr, GPRWr, DMWr, Bsel, MemByte, WDsel, GPRsel, Extop,
           ALUOp, ALUsel, NPCOp, PrWe, CP0We, EXLSet, EXLClr, eret
  );

  modport slave (
    output opcode, funct, rs_out, zero, flow, dev_sel, intreq,
    input  PCWr, IRWr, GPRWr, DMWr, Bsel, MemByte, WDsel, GPRsel, Extop,
           ALUOp, ALUsel, NPCOp, PrWe, CP0We, EXLSet, EXLClr, eret
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back,
// CP0 moves, eret and interrupt entry; outputs decode combinationally from state and IR.
module mc_ctrl (
  input  logic      clk,
  input  logic      rst,
  mc_ctrl_if.master bus
);
  localparam int unsigned OP_W = 6;
  localparam int unsigned RS_W = 5;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0d;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0f;
  localparam logic [OP_W-1:0] OP_COP0  = 6'h10;
  localparam logic [OP_W-1:0] OP_LB    = 6'h20;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SB    = 6'h28;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2b;

  localparam logic [OP_W-1:0] FN_JR    = 6'h08;
  localparam logic [OP_W-1:0] FN_ERET  = 6'h18;
  localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;
  localparam logic [OP_W-1:0] FN_AND   = 6'h24;
  localparam logic [OP_W-1:0] FN_OR    = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT   = 6'h2a;

  localparam logic [RS_W-1:0] RS_MFC0  = 5'h00;
  localparam logic [RS_W-1:0] RS_MTC0  = 5'h04;

  localparam logic [2:0] WD_ALU    = 3'b000;
  localparam logic [2:0] WD_DM     = 3'b001;
  localparam logic [2:0] WD_PC4    = 3'b010;
  localparam logic [2:0] WD_BRIDGE = 3'b011;
  localparam logic [2:0] WD_CP0    = 3'b100;

  localparam logic [1:0] GS_RT   = 2'b00;
  localparam logic [1:0] GS_RD   = 2'b01;
  localparam logic [1:0] GS_R31  = 2'b11;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_HI   = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;
  localparam logic [1:0] SEL_OP  = 2'b00;
  localparam logic [1:0] SEL_SLT = 2'b01;
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DCD, S_EXE, S_MEM, S_WB, S_INT
  } state_t;

  typedef enum logic [4:0] {
    I_ADDU, I_SUBU, I_AND, I_OR, I_SLT, I_JR, I_J, I_JAL, I_BEQ, I_ADDI,
    I_ORI, I_LUI, I_LW, I_LB, I_SW, I_SB, I_ERET, I_MFC0, I_MTC0, I_ILL
  } instr_t;

  state_t state, state_nxt, fetch_nxt;
  instr_t instr;
  logic   is_r_alu, is_load, is_store;

  logic       pc_wr, ir_wr, gpr_wr, dm_wr, b_sel, mem_byte;
  logic [2:0] wd_sel;
  logic [1:0] gpr_sel, ext_op, alu_op, alu_sel, npc_op;
  logic       pr_we, cp0_we, exl_set, exl_clr, eret_o;

  // Instruction class from the IR fields; anything unrecognised is a nop.
  always_comb begin
    instr = I_ILL;
    case (bus.opcode)
      OP_RTYPE: begin
        case (bus.funct)
          FN_ADDU: instr = I_ADDU;
          FN_SUBU: instr = I_SUBU;
          FN_AND:  instr = I_AND;
          FN_OR:   instr = I_OR;
          FN_SLT:  instr = I_SLT;
          FN_JR:   instr = I_JR;
          default: instr = I_ILL;
        endcase
      end
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      OP_BEQ:  instr = I_BEQ;
      OP_ADDI: instr = I_ADDI;
      OP_ORI:  instr = I_ORI;
      OP_LUI:  instr = I_LUI;
      OP_LW:   instr = I_LW;
      OP_LB:   instr = I_LB;
      OP_SW:   instr = I_SW;
      OP_SB:   instr = I_SB;
      OP_COP0: begin
        if (bus.funct == FN_ERET)       instr = I_ERET;
        else if (bus.rs_out == RS_MFC0) instr = I_MFC0;
        else if (bus.rs_out == RS_MTC0) instr = I_MTC0;
        else                            instr = I_ILL;
      end
      default: instr = I_ILL;
    endcase
  end

  assign is_r_alu = instr inside {I_ADDU, I_SUBU, I_AND, I_OR, I_SLT};
  assign is_load  = instr inside {I_LW, I_LB};
  assign is_store = instr inside {I_SW, I_SB};

  // Interrupts are only taken where an instruction retires into FETCH.
  assign fetch_nxt = bus.intreq ? S_INT : S_FETCH;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_wr     = 1'b0;
    ir_wr     = 1'b0;
    gpr_wr    = 1'b0;
    dm_wr     = 1'b0;
    b_sel     = 1'b0;
    mem_byte  = 1'b0;
    wd_sel    = WD_ALU;
    gpr_sel   = GS_RT;
    ext_op    = EXT_ZERO;
    alu_op    = ALU_ADD;
    alu_sel   = SEL_OP;
    npc_op    = NPC_PC4;
    pr_we     = 1'b0;
    cp0_we    = 1'b0;
    exl_set   = 1'b0;
    exl_clr   = 1'b0;
    eret_o    = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        pc_wr     = 1'b1;
        ir_wr     = 1'b1;
        npc_op    = NPC_PC4;
        state_nxt = S_DCD;
      end
      S_DCD: begin
        state_nxt = fetch_nxt;
        case (instr)
          I_J: begin
            pc_wr  = 1'b1;
            npc_op = NPC_J;
          end
          I_JAL: begin
            pc_wr   = 1'b1;
            npc_op  = NPC_J;
            gpr_wr  = 1'b1;
            gpr_sel = GS_R31;
            wd_sel  = WD_PC4;
          end
          I_JR: begin
            pc_wr  = 1'b1;
            npc_op = NPC_JR;
          end
          I_ERET: begin
            pc_wr   = 1'b1;
            eret_o  = 1'b1;
            exl_clr = 1'b1;
          end
          I_MFC0: begin
            gpr_wr  = 1'b1;
            gpr_sel = GS_RT;
            wd_sel  = WD_CP0;
          end
          I_ILL:   state_nxt = fetch_nxt;
          default: state_nxt = S_EXE;
        endcase
      end
      S_EXE: begin
        state_nxt = S_WB;
        case (instr)
          I_ADDU: alu_op = ALU_ADD;
          I_SUBU: alu_op = ALU_SUB;
          I_AND:  alu_op = ALU_AND;
          I_OR:   alu_op = ALU_OR;
          // slt takes the sign of a subtraction
          I_SLT: begin
            alu_op  = ALU_SUB;
            alu_sel = SEL_SLT;
          end
          I_ORI: begin
            b_sel  = 1'b1;
            ext_op = EXT_ZERO;
            alu_op = ALU_OR;
          end
          I_LUI: begin
            b_sel  = 1'b1;
            ext_op = EXT_HI;
            alu_op = ALU_OR;
          end
          I_ADDI: begin
            b_sel  = 1'b1;
            ext_op = EXT_SIGN;
            alu_op = ALU_ADD;
          end
          I_LW, I_LB, I_SW, I_SB: begin
            b_sel     = 1'b1;
            ext_op    = EXT_SIGN;
            alu_op    = ALU_ADD;
            state_nxt = S_MEM;
          end
          I_MTC0: begin
            cp0_we    = 1'b1;
            state_nxt = fetch_nxt;
          end
          I_BEQ: begin
            alu_op    = ALU_SUB;
            npc_op    = NPC_BR;
            pc_wr     = bus.zero;
            state_nxt = fetch_nxt;
          end
          default: state_nxt = fetch_nxt;
        endcase
      end
      S_MEM: begin
        state_nxt = is_load ? S_WB : fetch_nxt;
        // A byte store to a peripheral is unsupported and silently dropped.
        if (is_store) begin
          dm_wr    = ~bus.dev_sel;
          mem_byte = ~bus.dev_sel & (instr == I_SB);
          pr_we    = bus.dev_sel & (instr == I_SW);
        end
      end
      S_WB: begin
        state_nxt = fetch_nxt;
        if (is_r_alu) begin
          gpr_wr  = 1'b1;
          gpr_sel = GS_RD;
        end else if (instr == I_ORI || instr == I_LUI) begin
          gpr_wr = 1'b1;
        end else if (instr == I_ADDI) begin
          gpr_wr = ~bus.flow;
        end else if (is_load) begin
          gpr_wr   = 1'b1;
          wd_sel   = bus.dev_sel ? WD_BRIDGE : WD_DM;
          mem_byte = (instr == I_LB);
        end
      end
      S_INT: begin
        pc_wr     = 1'b1;
        exl_set   = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.PCWr    = pc_wr;
  assign bus.IRWr    = ir_wr;
  assign bus.GPRWr   = gpr_wr;
  assign bus.DMWr    = dm_wr;
  assign bus.Bsel    = b_sel;
  assign bus.MemByte = mem_byte;
  assign bus.WDsel   = wd_sel;
  assign bus.GPRsel  = gpr_sel;
  assign bus.Extop   = ext_op;
  assign bus.ALUOp   = alu_op;
  assign bus.ALUsel  = alu_sel;
  assign bus.NPCOp   = npc_op;
  assign bus.PrWe    = pr_we;
  assign bus.CP0We   = cp0_we;
  assign bus.EXLSet  = exl_set;
  assign bus.EXLClr  = exl_clr;
  assign bus.eret    = eret_o;
endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed latency/output table, hand-written interrupt and
// reset sequences, then random instruction streams against a phase-list model.
module tb_mc_ctrl;
  typedef struct packed {
    logic       PCWr, IRWr, GPRWr, DMWr, Bsel, MemByte;
    logic [2:0] WDsel;
    logic [1:0] GPRsel, Extop, ALUOp, ALUsel, NPCOp;
    logic       PrWe, CP0We, EXLSet, EXLClr, eret;
  } outs_t;

  typedef enum int {
    M_ADDU, M_SUBU, M_AND, M_OR, M_SLT, M_JR, M_J, M_JAL, M_BEQ, M_ADDI,
    M_ORI, M_LUI, M_LW, M_LB, M_SW, M_SB, M_ERET, M_MFC0, M_MTC0, M_ILL
  } mn_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs;
    logic       z, f, d;
    int         lat;
    int         ph;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  outs_t exp_seq[6];
  int    exp_n;
  vec_t  tbl[16];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic outs_t ov(input logic pc, ir, gw, dw, bs, mb,
                               input logic [2:0] wd, input logic [1:0] gs, ex, ao, as, np,
                               input logic pw, cw, es, ec, er);
    outs_t o;
    o = '{pc, ir, gw, dw, bs, mb, wd, gs, ex, ao, as, np, pw, cw, es, ec, er};
    return o;
  endfunction

  function automatic outs_t fetch_v();
    outs_t o = '0;
    o.PCWr = 1'b1;
    o.IRWr = 1'b1;
    return o;
  endfunction

  function automatic outs_t int_v();
    outs_t o = '0;
    o.PCWr   = 1'b1;
    o.EXLSet = 1'b1;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = '{bus.PCWr, bus.IRWr, bus.GPRWr, bus.DMWr, bus.Bsel, bus.MemByte, bus.WDsel,
          bus.GPRsel, bus.Extop, bus.ALUOp, bus.ALUsel, bus.NPCOp, bus.PrWe,
          bus.CP0We, bus.EXLSet, bus.EXLClr, bus.eret};
    return o;
  endfunction

  task automatic cmp(input string name, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: outputs got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check(input string name, input outs_t exp);
    cmp(name, sample(), exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ir(input logic [5:0] op, fn, input logic [4:0] rs,
                        input logic z, f, d);
    bus.opcode  = op;
    bus.funct   = fn;
    bus.rs_out  = rs;
    bus.zero    = z;
    bus.flow    = f;
    bus.dev_sel = d;
  endtask

  function automatic mn_t decode(input logic [5:0] op, fn, input logic [4:0] rs);
    case (op)
      6'h00: begin
        case (fn)
          6'h21: return M_ADDU;
          6'h23: return M_SUBU;
          6'h24: return M_AND;
          6'h25: return M_OR;
          6'h2a: return M_SLT;
          6'h08: return M_JR;
          default: return M_ILL;
        endcase
      end
      6'h02: return M_J;
      6'h03: return M_JAL;
      6'h04: return M_BEQ;
      6'h08: return M_ADDI;
      6'h0d: return M_ORI;
      6'h0f: return M_LUI;
      6'h23: return M_LW;
      6'h20: return M_LB;
      6'h2b: return M_SW;
      6'h28: return M_SB;
      6'h10: begin
        if (fn == 6'h18) return M_ERET;
        if (rs == 5'h00) return M_MFC0;
        if (rs == 5'h04) return M_MTC0;
        return M_ILL;
      end
      default: return M_ILL;
    endcase
  endfunction

  task automatic encode(input mn_t m, output logic [5:0] op, fn, output logic [4:0] rs);
    fn = 6'($urandom);
    rs = 5'($urandom);
    case (m)
      M_ADDU: begin op = 6'h00; fn = 6'h21; end
      M_SUBU: begin op = 6'h00; fn = 6'h23; end
      M_AND:  begin op = 6'h00; fn = 6'h24; end
      M_OR:   begin op = 6'h00; fn = 6'h25; end
      M_SLT:  begin op = 6'h00; fn = 6'h2a; end
      M_JR:   begin op = 6'h00; fn = 6'h08; end
      M_J:    op = 6'h02;
      M_JAL:  op = 6'h03;
      M_BEQ:  op = 6'h04;
      M_ADDI: op = 6'h08;
      M_ORI:  op = 6'h0d;
      M_LUI:  op = 6'h0f;
      M_LW:   op = 6'h23;
      M_LB:   op = 6'h20;
      M_SW:   op = 6'h2b;
      M_SB:   op = 6'h28;
      M_ERET: begin op = 6'h10; fn = 6'h18; rs = 5'h10; end
      M_MFC0: begin op = 6'h10; fn = 6'h00; rs = 5'h00; end
      M_MTC0: begin op = 6'h10; fn = 6'h00; rs = 5'h04; end
      default: begin op = 6'h3f; end
    endcase
  endtask

  // Reference: the ordered list of per-cycle output vectors one instruction produces.
  task automatic build(input mn_t m, input logic z, f, d);
    outs_t dc, ex, me, wb;
    bit has_ex, has_me, has_wb;
    dc = '0; ex = '0; me = '0; wb = '0;
    has_ex = 1'b1; has_me = 1'b0; has_wb = 1'b0;
    case (m)
      M_J:    begin dc.PCWr = 1; dc.NPCOp = 2'b10; has_ex = 0; end
      M_JAL:  begin dc.PCWr = 1; dc.NPCOp = 2'b10; dc.GPRWr = 1; dc.GPRsel = 2'b11;
                    dc.WDsel = 3'b010; has_ex = 0; end
      M_JR:   begin dc.PCWr = 1; dc.NPCOp = 2'b11; has_ex = 0; end
      M_ERET: begin dc.PCWr = 1; dc.eret = 1; dc.EXLClr = 1; has_ex = 0; end
      M_MFC0: begin dc.GPRWr = 1; dc.WDsel = 3'b100; has_ex = 0; end
      M_ILL:  has_ex = 0;
      M_ADDU, M_SUBU, M_AND, M_OR, M_SLT: begin
        ex.ALUOp  = (m == M_ADDU) ? 2'b00 : (m == M_OR) ? 2'b10 : (m == M_AND) ? 2'b11 : 2'b01;
        ex.ALUsel = (m == M_SLT) ? 2'b01 : 2'b00;
        wb.GPRWr = 1; wb.GPRsel = 2'b01; has_wb = 1;
      end
      M_ORI, M_LUI, M_ADDI: begin
        ex.Bsel  = 1;
        ex.Extop = (m == M_ORI) ? 2'b00 : (m == M_LUI) ? 2'b10 : 2'b01;
        ex.ALUOp = (m == M_ADDI) ? 2'b00 : 2'b10;
        wb.GPRWr = (m == M_ADDI) ? ~f : 1'b1;
        has_wb = 1;
      end
      M_LW, M_LB: begin
        ex.Bsel = 1; ex.Extop = 2'b01; has_me = 1; has_wb = 1;
        wb.GPRWr = 1; wb.WDsel = d ? 3'b011 : 3'b001; wb.MemByte = (m == M_LB);
      end
      M_SW, M_SB: begin
        ex.Bsel = 1; ex.Extop = 2'b01; has_me = 1;
        me.DMWr = ~d; me.MemByte = (m == M_SB) & ~d; me.PrWe = (m == M_SW) & d;
      end
      M_MTC0: ex.CP0We = 1;
      M_BEQ:  begin ex.ALUOp = 2'b01; ex.NPCOp = 2'b01; ex.PCWr = z; end
      default: ;
    endcase
    exp_seq[0] = fetch_v();
    exp_seq[1] = dc;
    exp_n = 2;
    if (has_ex) begin exp_seq[exp_n] = ex; exp_n++; end
    if (has_me) begin exp_seq[exp_n] = me; exp_n++; end
    if (has_wb) begin exp_seq[exp_n] = wb; exp_n++; end
  endtask

  initial begin
    outs_t obs[10];
    int lat;
    logic [5:0] op, fn;
    logic [4:0] rs;
    logic z, f, d, irq;
    mn_t m;

    //            PC IR GW DW BS MB WD      GS     EX     AO     AS     NP     PW CW ES EC ER
    tbl[0]  = '{"addu_wb",   6'h00, 6'h21, 5'h01, 0, 0, 0, 4, 3, ov(0,0,1,0,0,0,3'b000,2'b01,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[1]  = '{"addu_exe",  6'h00, 6'h21, 5'h01, 0, 0, 0, 4, 2, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[2]  = '{"lw_dm_wb",  6'h23, 6'h04, 5'h02, 0, 0, 0, 5, 4, ov(0,0,1,0,0,0,3'b001,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[3]  = '{"lw_dev_wb", 6'h23, 6'h04, 5'h02, 0, 0, 1, 5, 4, ov(0,0,1,0,0,0,3'b011,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[4]  = '{"sb_dm_mem", 6'h28, 6'h01, 5'h03, 0, 0, 0, 4, 3, ov(0,0,0,1,0,1,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[5]  = '{"sw_dev_mem",6'h2b, 6'h00, 5'h03, 0, 0, 1, 4, 3, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0,0,0)};
    tbl[6]  = '{"beq_taken", 6'h04, 6'h10, 5'h01, 1, 0, 0, 3, 2, ov(1,0,0,0,0,0,3'b000,2'b00,2'b00,2'b01,2'b00,2'b01,0,0,0,0,0)};
    tbl[7]  = '{"beq_not",   6'h04, 6'h10, 5'h01, 0, 0, 0, 3, 2, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b01,2'b00,2'b01,0,0,0,0,0)};
    tbl[8]  = '{"addi_ovf",  6'h08, 6'h3f, 5'h01, 0, 1, 0, 4, 3, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[9]  = '{"addi_ok",   6'h08, 6'h3f, 5'h01, 0, 0, 0, 4, 3, ov(0,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[10] = '{"op3f_dcd",  6'h3f, 6'h21, 5'h00, 1, 1, 1, 2, 1, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[11] = '{"jal_dcd",   6'h03, 6'h00, 5'h00, 0, 0, 0, 2, 1, ov(1,0,1,0,0,0,3'b010,2'b11,2'b00,2'b00,2'b00,2'b10,0,0,0,0,0)};
    tbl[12] = '{"mtc0_exe",  6'h10, 6'h00, 5'h04, 0, 0, 0, 3, 2, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,1,0,0,0)};
    tbl[13] = '{"lui_exe",   6'h0f, 6'h00, 5'h00, 0, 0, 0, 4, 2, ov(0,0,0,0,1,0,3'b000,2'b00,2'b10,2'b10,2'b00,2'b00,0,0,0,0,0)};
    tbl[14] = '{"sb_dev_mem",6'h28, 6'h01, 5'h03, 0, 0, 1, 4, 3, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0)};
    tbl[15] = '{"slt_exe",   6'h00, 6'h2a, 5'h01, 0, 0, 0, 4, 2, ov(0,0,0,0,0,0,3'b000,2'b00,2'b00,2'b01,2'b01,2'b00,0,0,0,0,0)};

    // Reset, with intreq held high across the release.
    rst = 1'b0;
    set_ir(6'h00, 6'h21, 5'h01, 0, 0, 0);
    bus.intreq = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_idle", '0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("first_fetch", fetch_v());
    bus.intreq = 1'b0;

    // Directed table: each starts at the negedge of its FETCH cycle.
    foreach (tbl[k]) begin
      set_ir(tbl[k].op, tbl[k].fn, tbl[k].rs, tbl[k].z, tbl[k].f, tbl[k].d);
      lat = -1;
      obs[0] = sample();
      for (int c = 1; c < 10; c++) begin
        obs[c] = '0;
        next_cycle();
        @(negedge clk);
        obs[c] = sample();
        if (obs[c].IRWr) begin
          lat = c;
          break;
        end
      end
      n_vec++;
      if (lat != tbl[k].lat) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", tbl[k].name, lat, tbl[k].lat);
      end
      cmp(tbl[k].name, obs[tbl[k].ph], tbl[k].exp);
    end

    // ori with intreq raised in EXE: retires, takes INT, then eret with intreq still high.
    set_ir(6'h0d, 6'h00, 5'h00, 0, 0, 0);
    next_cycle(); @(negedge clk); check("ori_dcd", '0);
    next_cycle(); bus.intreq = 1'b1;
    @(negedge clk); check("ori_exe", ov(0,0,0,0,1,0,3'b000,2'b00,2'b00,2'b10,2'b00,2'b00,0,0,0,0,0));
    next_cycle(); @(negedge clk); check("ori_wb", ov(0,0,1,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0));
    next_cycle(); @(negedge clk); check("ori_int", int_v());
    set_ir(6'h10, 6'h18, 5'h10, 0, 0, 0);
    next_cycle(); @(negedge clk); check("int_to_fetch", fetch_v());
    next_cycle(); @(negedge clk); check("eret_dcd", ov(1,0,0,0,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,1,1));
    next_cycle(); @(negedge clk); check("eret_reenter_int", int_v());
    bus.intreq = 1'b0;
    next_cycle(); @(negedge clk); check("eret_int_fetch", fetch_v());

    // intreq pulse that drops before the boundary is ignored.
    set_ir(6'h00, 6'h25, 5'h00, 0, 0, 0);
    next_cycle(); bus.intreq = 1'b1;
    next_cycle(); bus.intreq = 1'b0;
    next_cycle(); @(negedge clk); check("pulse_or_wb", ov(0,0,1,0,0,0,3'b000,2'b01,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0));
    next_cycle(); @(negedge clk); check("pulse_ignored", fetch_v());

    // Reset asserted during MEM of sw drops DMWr at once.
    set_ir(6'h2b, 6'h00, 5'h00, 0, 0, 0);
    repeat (3) next_cycle();
    @(negedge clk); check("sw_mem", ov(0,0,0,1,0,0,3'b000,2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,0));
    #1 rst = 1'b0;
    #1 check("rst_mid_mem", '0);
    next_cycle();
    rst = 1'b1;
    next_cycle(); @(negedge clk); check("rst_refetch", fetch_v());

    // Random instruction stream against the phase-list model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        m = mn_t'($urandom_range(0, 18));
        encode(m, op, fn, rs);
      end else begin
        op = 6'($urandom); fn = 6'($urandom); rs = 5'($urandom);
      end
      m = decode(op, fn, rs);
      z = 1'($urandom); f = 1'($urandom); d = 1'($urandom);
      set_ir(op, fn, rs, z, f, d);
      build(m, z, f, d);
      for (int i = 1; i < exp_n; i++) begin
        next_cycle();
        bus.intreq = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        check($sformatf("%s_ph%0d", m.name(), i), exp_seq[i]);
      end
      irq = bus.intreq;
      next_cycle();
      bus.intreq = ($urandom_range(0, 3) == 0);
      if (irq) begin
        @(negedge clk);
        check($sformatf("%s_int", m.name()), int_v());
        next_cycle();
      end
      @(negedge clk);
      check($sformatf("%s_next_fetch", m.name()), fetch_v());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
